subtree_rr_scheduler: RTL
=========================

Name: subtree_rr_scheduler

Overview:
- Round-robin scheduler that time-shares one resource among the NUM_REQ child instances of a generated subtree level (default five children).
- Each child raises a request; the scheduler grants exactly one child at a time, holds the grant until that child signals done, and forces release after MAX_HOLD cycles.
- Sits beside the subtree root and drives the per-child enables.

Parameters:
- NUM_REQ, 5, number of requesters; legal range 2..16.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal minimum 2.
- CNT_W, 16, width of the saturating grant counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-child request, level-sensitive.
- done  in  NUM_REQ  per-child completion pulse; only the bit of the current owner is honoured.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_valid  out  1  high while any grant is held (OR of gnt).
- gnt_id  out  ID_W  index of the current owner, where ID_W = max(1, clog2(NUM_REQ)); holds the last owner when idle.
- timeout  out  1  one-cycle pulse when a grant is force-released.
- grant_cnt  out  CNT_W  total grants issued; saturates at all-ones.

Behaviour:
- Reset: synchronous, active-high, takes effect at the clk edge where rst=1.
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0, grant_cnt=0.
  - Internal pointer ptr=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops gnt on that edge, with no timeout pulse.
- State IDLE:
  - If req is nonzero, pick the first index i with req[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - On the next edge: gnt=one-hot(i), gnt_id=i, hold=0, grant_cnt increments, state=GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req is zero, stay in IDLE with gnt=0.
- State GRANT:
  - hold increments each cycle.
  - Release condition, evaluated in this priority order:
    1. done[gnt_id]=1.
    2. req[gnt_id]=0.
    3. hold==MAX_HOLD-1; only this case pulses timeout=1 on the release edge.
  - On release: gnt=0, ptr=(gnt_id+1) mod NUM_REQ (wraps NUM_REQ-1 to 0), state=IDLE.
  - Every grant is therefore followed by at least one cycle with gnt=0. A requester still asserting req may be regranted only after all others with req asserted have been served.
  - done and req of non-owners are ignored during GRANT.
  - Maximum continuous gnt high for one owner is exactly MAX_HOLD cycles.
- Simultaneous done and timeout on the same cycle: counts as a normal release; no timeout pulse.
- grant_cnt: increments on each IDLE-to-GRANT transition; once all-ones, holds there.
- Invariants for the verifier:
  - gnt is one-hot or zero on every cycle.
  - gnt_valid == |gnt.
  - timeout is never high on two consecutive cycles.

Test Plan:
1. Single requester: req=5'b00100 held, done pulsed on the 3rd grant cycle -> gnt=00100 from cycle 1 after req, gnt_id=2, gnt high 3 cycles, then gnt=0 for 1 cycle, then regranted to child 2; grant_cnt=2.
2. All request: req=5'b11111 held, each owner pulses done after 2 cycles -> grant order 0,1,2,3,4,0, each grant separated by 1 idle cycle; grant_cnt=6.
3. Timeout: MAX_HOLD=8, req=00001 held, done never asserted -> gnt high exactly 8 cycles, timeout pulses once on the release edge, ptr=1.
4. Foreign done: child 1 owns the grant while done=5'b01000 (child 3) is pulsed -> grant to child 1 unaffected; child 1 dropping req releases with timeout=0.
5. Reset mid-grant: rst=1 on grant cycle 4 of child 3 -> next cycle gnt=0, gnt_id=0, grant_cnt=0, timeout=0; after rst drops with req=11111, the first grant goes to child 0.
6. Saturation and wrap: CNT_W=3, child 4 and child 0 alternate over 10 grants -> grant_cnt stops at 7; after each child-4 grant, ptr wraps to 0 and child 0 is chosen next.

Source files
------------

// File: rtl/subtree_rr_scheduler.sv
// Round-robin scheduler that time-shares one resource among the children of a
// generated subtree level. Exactly one child owns the grant at a time. The grant
// is held until the owner signals done or drops its request. It is also forced
// free after MAX_HOLD cycles. Every release is followed by at least one idle
// cycle. The next search starts just past the previous owner, so a child that
// keeps requesting cannot starve the others.
module subtree_rr_scheduler #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16,
  localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout,
  output logic [CNT_W-1:0]   grant_cnt
);

  // The hold counter only needs to reach MAX_HOLD-1. A grant then lasts exactly
  // MAX_HOLD cycles: counter values 0 .. MAX_HOLD-1.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Round-robin pick signals.
  logic               hi_found;
  logic [ID_W-1:0]    hi_id;
  logic               lo_found;
  logic [ID_W-1:0]    lo_id;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;

  // Owner release conditions.
  logic               own_done;
  logic               own_req;
  logic               hold_expired;

  // Round-robin search. A circular search from ptr picks the lowest requester
  // at or above ptr. If there is none, it wraps and picks the lowest requester
  // overall. Scanning downwards lets the last hit be the lowest index.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_id    = hi_found ? hi_id : lo_id;
  end

  // Decode the owner's own done/req bits. Bits from non-owners are ignored.
  always_comb begin
    own_done     = done[id_q];
    own_req      = req[id_q];
    hold_expired = (hold_q == HOLD_LAST);
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          gnt_d   = NUM_REQ'(1) << pick_id;
          id_d    = pick_id;
          hold_d  = '0;
          state_d = GRANT;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      GRANT: begin
        if (own_done || !own_req || hold_expired) begin
          // done and a dropped request take priority over the hold limit. Only
          // a pure hold expiry counts as a forced release.
          timeout_d = !own_done && own_req;
          gnt_d     = '0;
          hold_d    = '0;
          ptr_d     = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset. A reset in mid-grant
  // drops the grant with no timeout pulse.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so that every flop samples
    // the values from before the edge, whatever order the statements are in.
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
  assign timeout   = timeout_q;
  assign grant_cnt = cnt_q;

endmodule
